// File: rtl/parking_zone_ctrl.sv
// Two-zone (university / public) parking controller with hour-of-day
// timekeeping and a scheduled afternoon capacity hand-over from the
// university zone to the public zone.
module parking_zone_ctrl #(
  parameter int CW             = 10,
  parameter int TICKS_PER_HOUR = 60,
  parameter int START_HOUR     = 8,
  parameter int TOTAL_CAP      = 700,
  parameter int UNI_CAP_INIT   = 500,
  parameter int UNI_CAP_MIN    = 200,
  parameter int SHIFT_STEP     = 50,
  parameter int SHIFT_HOUR_A   = 14,
  parameter int SHIFT_HOUR_B   = 15,
  parameter int RESTORE_HOUR   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          car_entered,
  input  logic          is_uni_car_entered,
  input  logic          car_exited,
  input  logic          is_uni_car_exited,
  output logic [CW-1:0] uni_parked_car,
  output logic [CW-1:0] parked_car,
  output logic [CW-1:0] uni_capacity,
  output logic [CW-1:0] public_capacity,
  output logic [CW-1:0] uni_vacated_space,
  output logic [CW-1:0] vacated_space,
  output logic          uni_is_vacated_space,
  output logic          is_vacated_space,
  output logic [4:0]    hour,
  output logic          entry_accepted,
  output logic          exit_accepted,
  output logic          exit_error
);

  localparam int PW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_HOUR - 1);
  localparam logic [CW-1:0] TOT        = CW'(TOTAL_CAP);
  localparam logic [CW-1:0] UCAP0      = CW'(UNI_CAP_INIT);
  localparam logic [CW-1:0] UMIN       = CW'(UNI_CAP_MIN);
  localparam logic [CW-1:0] STEP       = CW'(SHIFT_STEP);
  localparam logic [4:0]    H_START    = 5'(START_HOUR);
  localparam logic [4:0]    H_A        = 5'(SHIFT_HOUR_A);
  localparam logic [4:0]    H_B        = 5'(SHIFT_HOUR_B);
  localparam logic [4:0]    H_RST      = 5'(RESTORE_HOUR);

  logic [PW-1:0] presc, presc_n;
  logic [4:0]    hour_n;
  logic          hour_tick;
  logic          uni_ent_ok, pub_ent_ok, uni_ex_ok, pub_ex_ok, ex_err;
  logic [CW-1:0] uni_cnt_n, pub_cnt_n, ucap_n, pcap_n;
  logic [CW-1:0] uvac_post, shift, u_rest;

  // Event arbitration on pre-cycle registered values, then hour/capacity update
  always_comb begin
    uni_ent_ok = car_entered &  is_uni_car_entered & uni_is_vacated_space;
    pub_ent_ok = car_entered & ~is_uni_car_entered & is_vacated_space;
    uni_ex_ok  = car_exited  &  is_uni_car_exited  & (uni_parked_car != '0);
    pub_ex_ok  = car_exited  & ~is_uni_car_exited  & (parked_car != '0);
    ex_err     = car_exited  & ~(uni_ex_ok | pub_ex_ok);

    uni_cnt_n  = uni_parked_car + CW'(uni_ent_ok) - CW'(uni_ex_ok);
    pub_cnt_n  = parked_car     + CW'(pub_ent_ok) - CW'(pub_ex_ok);

    hour_tick  = (presc == PRESC_LAST);
    presc_n    = hour_tick ? '0 : presc + 1'b1;
    hour_n     = !hour_tick ? hour : (hour == 5'd23) ? 5'd0 : hour + 5'd1;

    // Capacity actions use post-event counts so counts never exceed capacity
    ucap_n     = uni_capacity;
    pcap_n     = public_capacity;
    uvac_post  = uni_capacity - uni_cnt_n;
    shift      = (uvac_post < STEP) ? uvac_post : STEP;
    u_rest     = (uni_cnt_n > UMIN) ? uni_cnt_n : UMIN;
    if (TOT - u_rest < pub_cnt_n) u_rest = TOT - pub_cnt_n;

    if (hour_tick && (hour_n == H_A || hour_n == H_B)) begin
      ucap_n = uni_capacity - shift;
      pcap_n = public_capacity + shift;
    end else if (hour_tick && hour_n == H_RST) begin
      ucap_n = u_rest;
      pcap_n = TOT - u_rest;
    end
  end

  // State and output registers; vacated values derived from next-state so
  // they always match the registered counts/capacities
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc                <= '0;
      hour                 <= H_START;
      uni_parked_car       <= '0;
      parked_car           <= '0;
      uni_capacity         <= UCAP0;
      public_capacity      <= TOT - UCAP0;
      uni_vacated_space    <= UCAP0;
      vacated_space        <= TOT - UCAP0;
      uni_is_vacated_space <= (UCAP0 != '0);
      is_vacated_space     <= (TOT - UCAP0 != '0);
      entry_accepted       <= 1'b0;
      exit_accepted        <= 1'b0;
      exit_error           <= 1'b0;
    end else begin
      presc                <= presc_n;
      hour                 <= hour_n;
      uni_parked_car       <= uni_cnt_n;
      parked_car           <= pub_cnt_n;
      uni_capacity         <= ucap_n;
      public_capacity      <= pcap_n;
      uni_vacated_space    <= ucap_n - uni_cnt_n;
      vacated_space        <= pcap_n - pub_cnt_n;
      uni_is_vacated_space <= (ucap_n != uni_cnt_n);
      is_vacated_space     <= (pcap_n != pub_cnt_n);
      entry_accepted       <= uni_ent_ok | pub_ent_ok;
      exit_accepted        <= uni_ex_ok | pub_ex_ok;
      exit_error           <= ex_err;
    end
  end

endmodule
